// File: rtl/seq_s_rca_addsub_if.sv
// Operand/result handshake bundle for the digit-serial signed adder/subtractor.
// The requester drives operands and out_ready; the adder drives in_ready, out_valid and out.
interface seq_s_rca_addsub_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/seq_s_rca_addsub.sv
// Digit-serial signed ripple-carry adder/subtractor: one D-bit slice per clock,
// registered inter-digit carry, exact (N+1)-bit two's-complement result.
module seq_s_rca_addsub #(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic                clk,
    input  logic                rst,
    seq_s_rca_addsub_if.slave   bus
);
    localparam int NDIG = N / D;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          carry;
    logic [KW-1:0] k;
    logic [N:0]    res;
    logic          rdy;

    logic          accept;
    logic          last;
    logic [D-1:0]  a_dig;
    logic [D-1:0]  b_dig;
    logic [D:0]    dsum;

    // The D-bit ripple slice shared by every digit position.
    always_comb begin
        accept = (state == IDLE) && rdy && bus.in_valid;
        last   = (state == RUN) && (k == K_LAST);
        a_dig  = a_q[int'(k) * D +: D];
        b_dig  = b_q[int'(k) * D +: D];
        dsum   = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, carry};
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            k     <= '0;
            res   <= '0;
            rdy   <= 1'b0;
        end else begin
            // Registered ready keeps in_ready low throughout reset and off any input path.
            rdy <= (state_nxt == IDLE);
            if (accept) begin
                a_q   <= bus.a;
                b_q   <= bus.b ^ {N{bus.sub}};
                carry <= bus.sub;
                k     <= '0;
            end else if (state == RUN) begin
                res[int'(k) * D +: D] <= dsum[D-1:0];
                carry <= dsum[D];
                k     <= last ? '0 : k + 1'b1;
                // Sign extension of both operands makes the top bit exact.
                if (last) res[N] <= a_q[N-1] ^ b_q[N-1] ^ dsum[D];
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = (state == DONE);
    assign bus.out       = res;
endmodule

// File: tb/tb_seq_s_rca_addsub.sv
// Self-checking bench: directed N=8/D=2 scenarios plus a parameter sweep against
// a sign-extended arithmetic model, with expected results queued at each accept.
module tb_seq_s_rca_addsub;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   sweep_left;

    logic [8:0] exp_q[$];

    seq_s_rca_addsub_if #(.N(8)) bus ();

    seq_s_rca_addsub #(.N(8), .D(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    // One full transaction on the N=8, D=2 instance, with optional DONE backpressure.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                         input logic [8:0] expv, input int hold);
        int w;
        int lat;
        logic [8:0] got;
        @(negedge clk);
        bus.a = ta; bus.b = tbv; bus.sub = ts;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 20) begin @(negedge clk); w++; end
        check("in_ready_before_accept", bus.in_ready, 1);
        exp_q.push_back(expv);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = ~ta; bus.b = ~tbv; bus.sub = ~ts;
        check("in_ready_in_run", bus.in_ready, 0);
        lat = 0;
        do begin @(posedge clk); lat++; @(negedge clk); end
        while (!bus.out_valid && lat < 40);
        check("latency", lat, 4);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.sub = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_out_stable", bus.out, expv);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("queue_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check("result", bus.out, got);
        end
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_xfer_out_valid", bus.out_valid, 0);
        check("post_xfer_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        int w;
        n_vec = 0; n_err = 0; sweep_left = 9;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out", bus.out, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);

        do_op(8'h7F, 8'h01, 1'b0, 9'h080, 0);
        do_op(8'h80, 8'h01, 1'b1, 9'h17F, 0);
        do_op(8'h80, 8'h80, 1'b0, 9'h100, 0);
        do_op(8'h00, 8'h80, 1'b1, 9'h080, 0);
        do_op(8'h05, 8'h05, 1'b1, 9'h000, 0);
        do_op(8'h3C, 8'hA5, 1'b1, 9'h097, 5);

        // Operands offered during backpressure must not have started a new operation.
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("no_capture_during_bp", bus.out_valid, 0);
        check("no_capture_in_ready", bus.in_ready, 1);

        // Abort an operation after two RUN cycles.
        bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; bus.in_valid = 1'b1;
        check("abort_ready", bus.in_ready, 1);
        exp_q.push_back(9'h033);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort_pre_valid", bus.out_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out_cleared", bus.out, 0);
        check("abort_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_no_valid", bus.out_valid, 0);
        check("abort_out_zero", bus.out, 0);
        do_op(8'h03, 8'hFE, 1'b0, 9'h001, 0);

        w = 0;
        while (sweep_left != 0 && w < 20000) begin @(negedge clk); w++; end
        check("sweep_complete", sweep_left, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Sweep N in {4,8,16}, D in {1,N/2,N}, each with its own instance and scoreboard.
    for (genvar g = 0; g < 9; g++) begin : sw
        localparam int SN = 4 << (g / 3);
        localparam int SD = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? SN / 2 : SN);

        logic          srst;
        logic [SN:0]   sq[$];

        seq_s_rca_addsub_if #(.N(SN)) sbus ();

        seq_s_rca_addsub #(.N(SN), .D(SD)) sdut (
            .clk (clk),
            .rst (srst),
            .bus (sbus)
        );

        initial begin
            logic [SN-1:0] va;
            logic [SN-1:0] vb;
            logic          vs;
            logic [SN:0]   ev;
            logic [SN:0]   got;
            int            w;
            int            lat;
            srst = 1'b1;
            sbus.in_valid = 1'b0; sbus.a = '0; sbus.b = '0; sbus.sub = 1'b0; sbus.out_ready = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            srst = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (i == 0) begin
                    va = '0; vb = {1'b1, {(SN-1){1'b0}}}; vs = 1'b1;
                end else if (i == 1) begin
                    va = {1'b1, {(SN-1){1'b0}}}; vb = {1'b1, {(SN-1){1'b0}}}; vs = 1'b0;
                end else if (i == 2) begin
                    va = {1'b0, {(SN-1){1'b1}}}; vb = SN'(1); vs = 1'b0;
                end else begin
                    va = SN'($urandom); vb = SN'($urandom); vs = 1'($urandom);
                end
                ev = vs ? ({va[SN-1], va} - {vb[SN-1], vb}) : ({va[SN-1], va} + {vb[SN-1], vb});
                sbus.a = va; sbus.b = vb; sbus.sub = vs; sbus.in_valid = 1'b1;
                w = 0;
                while (!sbus.in_ready && w < 20) begin @(negedge clk); w++; end
                check($sformatf("sweep_ready_n%0d_d%0d", SN, SD), sbus.in_ready, 1);
                sq.push_back(ev);
                @(posedge clk);
                @(negedge clk);
                sbus.in_valid = 1'b0;
                lat = 0;
                do begin @(posedge clk); lat++; @(negedge clk); end
                while (!sbus.out_valid && lat < 60);
                check($sformatf("sweep_latency_n%0d_d%0d", SN, SD), lat, SN / SD);
                if (sq.size() != 0) begin
                    got = sq.pop_front();
                    check($sformatf("sweep_result_n%0d_d%0d", SN, SD), sbus.out, got);
                end
                @(posedge clk);
                @(negedge clk);
            end
            sweep_left--;
        end
    end
endmodule
